// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared opcode encodings and status-flag bit positions for
//                the pipelined ALU and its combinational core.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Operation encodings carried on in_op
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_SHL  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_SHR  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    // Bit positions inside the 4-bit {V,N,Z,C} flag vector
    localparam int FLG_C = 0;
    localparam int FLG_Z = 1;
    localparam int FLG_N = 2;
    localparam int FLG_V = 3;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
//  Module      : alu_core
//  Description : Purely combinational WIDTH-bit ALU, (a,b,op) -> result and
//                {V,N,Z,C} flags. Carry holds the borrow for SUB and the
//                shifted-out bit for the shifts.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_r;
    logic             w_c;
    logic             w_v;

    // Extended-width add/subtract so the top bit is carry or borrow directly
    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} - {1'b0, b};

    // Operation select; V only meaningful for the arithmetic ops
    always_comb begin
        w_r = '0;
        w_c = 1'b0;
        w_v = 1'b0;
        case (op)
            OP_ADD: begin
                w_r = w_sum[WIDTH-1:0];
                w_c = w_sum[WIDTH];
                w_v = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                w_r = w_diff[WIDTH-1:0];
                w_c = w_diff[WIDTH];
                w_v = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_XOR: w_r = a ^ b;
            OP_SHL: begin
                w_r = {a[WIDTH-2:0], 1'b0};
                w_c = a[WIDTH-1];
            end
            OP_AND: w_r = a & b;
            OP_OR:  w_r = a | b;
            OP_SHR: begin
                w_r = {1'b0, a[WIDTH-1:1]};
                w_c = a[0];
            end
            default: w_r = a;
        endcase
    end

    // Flag vector assembly from the selected result
    always_comb begin
        flags        = 4'b0000;
        flags[FLG_C] = w_c;
        flags[FLG_Z] = (w_r == '0);
        flags[FLG_N] = w_r[WIDTH-1];
        flags[FLG_V] = w_v;
    end

    assign result = w_r;

endmodule : alu_core
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pipe
//  Description : Two-stage valid/ready pipelined ALU with an accumulator that
//                can stand in for operand B. S1 holds operands, S2 holds the
//                computed result and flags. The accumulator is updated on
//                every S1->S2 transfer, so a use_acc beat always sees the
//                result of the beat directly ahead of it.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe
    import alu_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_use_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags
);

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [2:0]       r_s1_op;
    logic             r_s1_use_acc;

    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_result;
    logic [3:0]       r_s2_flags;

    logic [WIDTH-1:0] r_acc;

    logic             w_s2_load;
    logic             w_in_ready;
    logic             w_in_fire;
    logic [WIDTH-1:0] w_op_b;
    logic [WIDTH-1:0] w_result;
    logic [3:0]       w_flags;

    // Handshake: S2 takes a new beat when empty or draining this cycle
    assign w_s2_load  = r_s1_valid && (!r_s2_valid || out_ready);
    assign w_in_ready = !r_s1_valid || w_s2_load;
    assign w_in_fire  = in_valid && w_in_ready;

    // B is resolved at compute time so the accumulator is never stale
    assign w_op_b = r_s1_use_acc ? r_acc : r_s1_b;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a      (r_s1_a),
        .b      (w_op_b),
        .op     (r_s1_op),
        .result (w_result),
        .flags  (w_flags)
    );

    // Stage 1: capture operands on input transfer, empty when passed on
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_a       <= '0;
            r_s1_b       <= '0;
            r_s1_op      <= OP_ADD;
            r_s1_use_acc <= 1'b0;
        end else begin
            if (w_in_fire) begin
                r_s1_valid   <= 1'b1;
                r_s1_a       <= in_a;
                r_s1_b       <= in_b;
                r_s1_op      <= in_op;
                r_s1_use_acc <= in_use_acc;
            end else if (w_s2_load) begin
                r_s1_valid   <= 1'b0;
            end
        end
    end

    // Stage 2: register result and flags, hold them while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid  <= 1'b0;
            r_s2_result <= '0;
            r_s2_flags  <= 4'b0000;
        end else begin
            if (w_s2_load) begin
                r_s2_valid  <= 1'b1;
                r_s2_result <= w_result;
                r_s2_flags  <= w_flags;
            end else if (out_ready) begin
                r_s2_valid  <= 1'b0;
            end
        end
    end

    // Accumulator tracks every computed result, regardless of use_acc
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= ACC_INIT;
        end else if (w_s2_load) begin
            r_acc <= w_result;
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_s2_valid;
    assign out_result = r_s2_result;
    assign out_flags  = r_s2_flags;

endmodule : alu_pipe
`default_nettype wire
